// File: rtl/sipo_pkg.sv
// Shared definitions for the word-serial datapath (collector and serializer sides).
package sipo_pkg;

  localparam int SIPO_COUNT      = 128;
  localparam int SIPO_DATA_WIDTH = 16;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } sipo_buf_state_t;

endpackage

// File: rtl/sipo_collector.sv
// Collects COUNT serial words into one vector, first word in the top slice.
// Latency: out_valid the cycle after the COUNTth accept; backpressure stalls only the final word.
module sipo_collector
  import sipo_pkg::*;
#(
  parameter int COUNT      = SIPO_COUNT,
  parameter int DATA_WIDTH = SIPO_DATA_WIDTH,
  parameter int CNT_W      = $clog2(COUNT)
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH*COUNT-1:0] A_out,
  output logic [CNT_W-1:0]            word_cnt
);

  localparam int               VEC_W    = DATA_WIDTH * COUNT;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  if (COUNT < 2) begin : g_count_check
    $error("sipo_collector: COUNT must be at least 2");
  end

  logic [VEC_W-1:0] shreg_q, shreg_d;
  logic [VEC_W-1:0] a_out_q, a_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sipo_buf_state_t  state_q, state_d;

  logic [VEC_W-1:0] shifted;
  logic             cnt_last;
  logic             accept;
  logic             final_acc;
  logic             drain;

  assign shifted   = {shreg_q[VEC_W-DATA_WIDTH-1:0], in_data};
  assign cnt_last  = (cnt_q == LAST_CNT);
  assign accept    = in_valid && in_ready;
  assign final_acc = accept && cnt_last;
  assign drain     = out_valid && out_ready;

  // Output buffer FSM: state register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= BUF_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output buffer FSM: next state. A drain coinciding with a new vector keeps the buffer full.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: if (final_acc)           state_d = BUF_FULL;
        BUF_FULL:  if (drain && !final_acc) state_d = BUF_EMPTY;
        default:                            state_d = BUF_EMPTY;
      endcase
    end
  end

  // Output buffer FSM: outputs. in_ready sees out_ready combinationally so a draining buffer
  // can take the next final word in the same cycle.
  always_comb begin
    out_valid = (state_q == BUF_FULL);
    in_ready  = !clear && !(cnt_last && out_valid && !out_ready);
  end

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (accept) begin
      if (cnt_last) begin
        shreg_d = '0;
        cnt_d   = '0;
      end else begin
        shreg_d = shifted;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  // A_out keeps the last vector after a drain until overwritten or cleared.
  always_comb begin
    a_out_d = a_out_q;
    if (clear) begin
      a_out_d = '0;
    end else if (final_acc) begin
      a_out_d = shifted;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a_out_q <= '0;
    end else begin
      a_out_q <= a_out_d;
    end
  end

  assign A_out    = a_out_q;
  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_sipo_collector.sv
// Directed and random checks of sipo_collector (COUNT=4, DATA_WIDTH=16) against a word-list model.
module tb_sipo_collector;

  localparam int CNT = 4;
  localparam int DW  = 16;
  localparam int VW  = CNT * DW;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          clear;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] A_out;
  logic [1:0]    word_cnt;

  sipo_collector #(.COUNT(CNT), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .clear    (clear),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .A_out    (A_out),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: words of the unfinished vector, every accepted word since the last flush,
  // whether a vector is held, and what A_out should show.
  logic [DW-1:0] part[$];
  logic [DW-1:0] stream[$];
  bit            mfull;
  logic [VW-1:0] ma;
  int            drained;
  int            ov_cycles;
  bit            last_acc;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] vec_at(input int k);
    logic [VW-1:0] v = '0;
    for (int i = 0; i < CNT; i++) v = (v << DW) | VW'(stream[k*CNT + i]);
    return v;
  endfunction

  task automatic model_reset();
    part.delete();
    stream.delete();
    mfull   = 1'b0;
    ma      = '0;
    drained = 0;
  endtask

  // One clock cycle: drive at edge+1, check in_ready mid-cycle, check outputs at next edge+1.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit ordy, input bit clr);
    bit exp_rdy, acc, drn, fin;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    #3;
    exp_rdy = !clr && !(part.size() == CNT-1 && mfull && !ordy);
    chk("in_ready", VW'(in_ready), VW'(exp_rdy));
    acc = v && exp_rdy;
    drn = mfull && ordy && !clr;
    if (drn) begin
      chk("drained_vector", A_out, vec_at(drained));
      drained++;
    end
    @(posedge clk);
    #1;
    if (clr) begin
      model_reset();
    end else begin
      fin = acc && (part.size() == CNT-1);
      if (acc) begin
        part.push_back(d);
        stream.push_back(d);
      end
      if (fin) begin
        ma = '0;
        foreach (part[i]) ma = (ma << DW) | VW'(part[i]);
        part.delete();
        mfull = 1'b1;
      end else if (drn) begin
        mfull = 1'b0;
      end
    end
    last_acc = acc;
    chk("out_valid", VW'(out_valid), VW'(mfull));
    chk("word_cnt", VW'(word_cnt), VW'(part.size()));
    chk("A_out", A_out, ma);
    if (out_valid) ov_cycles++;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit ordy);
    int n = 0;
    do begin
      cycle(1'b1, d, ordy, 1'b0);
      n++;
    end while (!last_acc && n < 50);
    if (!last_acc) chk("send_timeout", VW'(last_acc), VW'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int total;
    bit v, ordy;

    // Reset state
    rst_b = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    #2;
    chk("rst_out_valid", VW'(out_valid), VW'(0));
    chk("rst_A_out", A_out, '0);
    chk("rst_word_cnt", VW'(word_cnt), VW'(0));
    #10 rst_b = 1'b1;
    #1;
    chk("rst_in_ready", VW'(in_ready), VW'(1));
    @(posedge clk);
    #1;

    // Basic: one vector, one-cycle out_valid pulse
    for (int i = 1; i <= 4; i++) send(DW'(i), 1'b1);
    chk("basic_vec", A_out, 64'h0001_0002_0003_0004);
    chk("basic_valid", VW'(out_valid), VW'(1));
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("basic_pulse_end", VW'(out_valid), VW'(0));

    // Backpressure: word 8 stalls until the consumer drains
    for (int i = 1; i <= 7; i++) send(DW'(i), 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 16'h0008, 1'b0, 1'b0);
      chk("bp_stall", VW'(in_ready), VW'(0));
      chk("bp_hold", A_out, 64'h0001_0002_0003_0004);
    end
    cycle(1'b1, 16'h0008, 1'b1, 1'b0);
    chk("bp_accept", VW'(last_acc), VW'(1));
    chk("bp_vec2", A_out, 64'h0005_0006_0007_0008);
    chk("bp_valid", VW'(out_valid), VW'(1));

    // Asynchronous reset mid-collection with a vector held
    send(16'h0009, 1'b0);
    in_valid = 1'b0;
    #2 rst_b = 1'b0;
    #1;
    chk("arst_out_valid", VW'(out_valid), VW'(0));
    chk("arst_A_out", A_out, '0);
    chk("arst_word_cnt", VW'(word_cnt), VW'(0));
    model_reset();
    @(posedge clk);
    #2 rst_b = 1'b1;
    #1;
    chk("arst_in_ready", VW'(in_ready), VW'(1));
    @(posedge clk);
    #1;

    // Continuous stream with simultaneous drain and fill
    ov_cycles = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b1, DW'(16'h0100 + i), 1'b1, 1'b0);
      chk("stream_acc", VW'(last_acc), VW'(1));
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("stream_valid_cycles", VW'(ov_cycles), VW'(3));

    // Clear flushes partial words, then flushes a held vector
    send(16'hAAAA, 1'b1);
    send(16'hBBBB, 1'b1);
    cycle(1'b1, 16'hCCCC, 1'b1, 1'b1);
    chk("clr_word_cnt", VW'(word_cnt), VW'(0));
    for (int i = 1; i <= 4; i++) send(DW'(i), 1'b0);
    chk("clr_vec", A_out, 64'h0001_0002_0003_0004);
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("clr_held_valid", VW'(out_valid), VW'(0));
    chk("clr_held_A_out", A_out, '0);

    // Random duty on both handshakes
    total = 0;
    for (int c = 0; c < 20000 && total < 1000; c++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      cycle(v, DW'($urandom), ordy, 1'b0);
      if (last_acc) total++;
    end
    for (int c = 0; c < 20 && mfull; c++) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("rand_done", VW'(total >= 1000), VW'(1));
    chk("rand_final_valid", VW'(out_valid), VW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_collector.md
# sipo_collector

Serial-in, parallel-out collector that accepts a stream of DATA_WIDTH-bit words over a valid/ready handshake and assembles every COUNT consecutive words into one DATA_WIDTH*COUNT-bit vector. The vector is held in a registered output buffer with its own valid/ready handshake, so collection of the next vector overlaps with the consumer draining the current one. It sits on the receive side of the accelerator's word-serial datapaths. Word order is top-slice first: the first word received lands in the most significant slice.

## Interface
- COUNT, default 128: words per vector; legal range is COUNT ≥ 2.
- DATA_WIDTH, default 16: bits per word.
- CNT_W, default $clog2(COUNT): width of word_cnt. Derived; not overridden.

- clk  input  1  clock; all logic is rising-edge.
- rst_b  input  1  reset; asynchronous, active-low.
- clear  input  1  synchronous flush; highest priority after reset.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  DATA_WIDTH  serial word.
- in_ready  output  1  collector can accept a word this cycle; combinational.
- out_valid  output  1  A_out holds a complete vector.
- out_ready  input  1  consumer takes A_out this cycle.
- A_out  output  DATA_WIDTH*COUNT  assembled vector; slice [DW*COUNT-1 -: DW] is the first word.
- word_cnt  output  CNT_W  number of words in the partial vector, 0..COUNT-1.

## Operation
- Accept: in_valid && in_ready. Drain: out_valid && out_ready.
- Shift register shreg (DW*COUNT bits) on accept: shreg <= {shreg[DW*(COUNT-1)-1:0], in_data}; word_cnt increments.
- Final word: an accept when word_cnt == COUNT-1.
  - A_out <= {shreg[DW*(COUNT-1)-1:0], in_data}.
  - shreg <= 0 and word_cnt <= 0.
  - Output buffer goes to FULL.
- Output buffer FSM, states BUF_EMPTY and BUF_FULL:
  - EMPTY→FULL on a final-word accept.
  - FULL→EMPTY on a drain with no final-word accept in the same cycle.
  - FULL stays FULL on a drain and a final-word accept in the same cycle; A_out takes the new vector.
  - out_valid = (state == BUF_FULL).
- in_ready = !clear && !(word_cnt == COUNT-1 && out_valid && !out_ready).
  - Non-final words are always accepted when clear is low.
  - A final word stalls only while the buffer is full and not draining.
- While out_valid is high and no drain occurs, A_out is stable.
- A_out is not cleared on drain; it keeps the last vector until overwritten.
- clear = 1:
  - shreg, word_cnt, out_valid and A_out all go to 0.
  - A held vector is discarded even if out_ready is high.
  - in_data is ignored that cycle.
- Reset values (rst_b low): shreg = 0, word_cnt = 0, A_out = 0, state = BUF_EMPTY, so out_valid = 0. in_ready = 1 once reset is released.
- Reset mid-collection discards the partial vector and any held vector immediately, without waiting for a clock edge.

## Timing
- Latency: out_valid rises on the clock edge that accepts the COUNTth word; it is visible the cycle after that accept.
- Throughput: one word per cycle sustained when out_ready is high in every cycle that out_valid is high, so there are no bubbles between vectors.
- Combinational paths:
  - out_ready → in_ready. The consumer must not make out_ready depend on in_ready.
  - clear → in_ready.
- in_valid may drop at any time. No accept occurs without in_ready.
- A drain is honoured in any cycle in which out_valid is high.

## Structure
- Shared package sipo_pkg:
  - typedef enum logic {BUF_EMPTY, BUF_FULL} sipo_buf_state_t.
  - Default COUNT and DATA_WIDTH localparams, shared with the serializer side of the same datapath.
- Single module. No sub-module: the shift register, counter and output buffer are each one always_ff.
- Add an assertion that COUNT ≥ 2.

## Test plan
All scenarios use COUNT=4, DATA_WIDTH=16.
- Reset: assert rst_b low mid-stream → out_valid=0, A_out=0, word_cnt=0 immediately; in_ready=1 after release.
- Basic: out_ready=1, send 0x0001, 0x0002, 0x0003, 0x0004 back-to-back → A_out=0x0001_0002_0003_0004 with a one-cycle out_valid pulse; word_cnt sequence 1, 2, 3, 0.
- Backpressure: out_ready=0, send 0x0001..0x0008 → first vector held stable; in_ready drops at word_cnt=3 with 0x0008 pending. Raise out_ready → 0x0008 accepted in the same cycle and A_out=0x0005_0006_0007_0008 the next cycle, with out_valid remaining high.
- Simultaneous drain and fill: stream 12 words continuously with out_ready=1 → three vectors, out_valid high for exactly three cycles (one per completion), no words dropped or duplicated.
- Clear: send 0xAAAA, 0xBBBB, then clear → word_cnt=0. Next four words 0x0001..0x0004 → A_out=0x0001_0002_0003_0004, containing no 0xAAAA or 0xBBBB. Clear while out_valid=1 and out_ready=1 → out_valid=0 and no drain occurs.
- Random: random in_valid/out_ready duty over 1000 words → scoreboard matches every vector in order.
